sobel_frame_ctrl: RTL and testbench
===================================

// Module: sobel_frame_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 Sobel datapath: raster address generation for the image ROM,
//  shift-register advance strobes, window-valid (conv start) generation and output tagging.
//  Sits between the top-level start/handshake and the ROM -> 3x3 shift register -> conv chain.
//  Adds output backpressure: the whole chain freezes while an output is offered but not taken.
// PARAMETERS
//  IMG_W    32  image width in pixels (>=3)
//  IMG_H    32  image height in pixels (>=3)
//  ADDR_W   10  ROM address width; IMG_W*IMG_H <= 2**ADDR_W
//  ROM_LAT  1   cycles from rom_en/rom_addr to valid ROM data
//  CONV_LAT 2   cycles from conv_start to conv result valid
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       synchronous active-low reset
//  start       in   1       begin one frame (sampled in IDLE only)
//  out_ready   in   1       downstream accepts current output
//  rom_en      out  1       ROM read enable
//  rom_addr    out  ADDR_W  ROM read address, raster order y*IMG_W+x
//  sr_shift    out  1       shift register: capture ROM data this cycle
//  conv_start  out  1       window registers hold a complete 3x3 window
//  pipe_en     out  1       global advance enable for ROM/shift reg/conv
//  out_valid   out  1       conv output valid
//  out_x       out  ADDR_W  centre column of current output (1..IMG_W-2)
//  out_y       out  ADDR_W  centre row of current output (1..IMG_H-2)
//  busy        out  1       high in FETCH or DRAIN
//  done        out  1       one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; every output 0; counters and delay pipes cleared.
//  Reset mid-frame aborts immediately; no done pulse; next start begins at address 0.
//  adv = !(out_valid && !out_ready); pipe_en = adv. When adv=0 every counter, delay stage,
//   rom_en/sr_shift/conv_start strobe and out_* holds; strobes are forced 0 for that cycle.
//  States: IDLE -> FETCH on start; FETCH -> DRAIN when address IMG_W*IMG_H-1 issued with adv;
//   DRAIN -> DONE when last output accepted (out_valid && out_ready) and no tokens in flight;
//   DONE -> IDLE unconditionally after 1 cycle (done=1 only in DONE). start outside IDLE ignored.
//  FETCH: cycle k (k=0 first FETCH cycle, adv=1 throughout) drives rom_en=1, rom_addr=k;
//   x counts 0..IMG_W-1 then wraps to 0 with y+1; address never exceeds IMG_W*IMG_H-1.
//  Token pipe carries (x,y) ROM_LAT stages; sr_shift=1 ROM_LAT adv-cycles after rom_en.
//  conv_start=1 one adv-cycle after an sr_shift whose pixel has x>=2 and y>=2 (window now full);
//   columns 0,1 of every row produce no conv_start (row-wrap windows discarded).
//  out_valid asserted CONV_LAT adv-cycles after conv_start, tagged out_x=x-1, out_y=y-1 of the
//   triggering pixel; held with tags stable until out_ready. Simultaneous new result and accept
//   in the same cycle: new result presented next cycle, no bubble, no loss.
//  Output count per frame exactly (IMG_W-2)*(IMG_H-2), raster order of centres.
//  All arithmetic unsigned ADDR_W wide; counters compare against IMG_W-1/IMG_H-1, no overflow.
// TESTING (default params, out_ready=1 unless stated; cycle 0 = first FETCH cycle)
//  T1 reset: hold rst_n=0 with start=1 -> all outputs 0, state IDLE; release -> FETCH next cycle.
//  T2 first output: rom_addr=66 at cycle 66, sr_shift at 67, conv_start at 68, out_valid at 70
//   with out_x=1,out_y=1; no conv_start for addresses 0..65.
//  T3 full frame: exactly 900 out_valid beats, 30 per row, last out_x=30,out_y=30 at cycle 1027;
//   done=1 at cycle 1028 only, busy low at 1029.
//  T4 backpressure: drop out_ready for 5 cycles at first out_valid -> rom_addr frozen, out_x/out_y
//   stable, no extra sr_shift; after release outputs resume 1/1, 1/2.. with none lost or repeated;
//   done delayed by exactly 5 cycles (1033).
//  T5 reset mid-frame at cycle 500 -> outputs 0 next edge, no done; new start gives T2 timing.
//  T6 start pulsed during FETCH/DRAIN/DONE -> ignored; single frame of 900 outputs, one done.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for the 3x3 Sobel chain (ROM addressing, shift strobes, window start, output tags)
// Ports:
//   clk, rst_n (sync, active-low), start, out_ready  -> control inputs
//   rom_en, rom_addr                                  -> raster-order ROM read
//   sr_shift, conv_start, pipe_en                     -> shift register / conv control
//   out_valid, out_x, out_y                           -> tagged conv output, held under backpressure
//   busy, done                                        -> frame status
module sobel_frame_ctrl #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int ADDR_W   = 10,
    parameter int ROM_LAT  = 1,
    parameter int CONV_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              out_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              sr_shift,
    output logic              conv_start,
    output logic              pipe_en,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_x,
    output logic [ADDR_W-1:0] out_y,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

    state_t state, state_nx;
    logic adv, in_flight;
    logic [ADDR_W-1:0] x, y;
    logic              t_v [ROM_LAT];
    logic [ADDR_W-1:0] t_x [ROM_LAT];
    logic [ADDR_W-1:0] t_y [ROM_LAT];
    logic              c_v;
    logic [ADDR_W-1:0] c_x, c_y;
    logic              d_v [CONV_LAT];
    logic [ADDR_W-1:0] d_x [CONV_LAT];
    logic [ADDR_W-1:0] d_y [CONV_LAT];

    // the whole chain stalls only while an offered result is refused
    assign adv        = !(out_valid && !out_ready);
    assign pipe_en    = adv && rst_n;
    assign sr_shift   = t_v[ROM_LAT-1] && adv;
    assign conv_start = c_v && adv;
    assign out_valid  = d_v[CONV_LAT-1];
    assign out_x      = d_x[CONV_LAT-1];
    assign out_y      = d_y[CONV_LAT-1];

    // any token still behind the output stage blocks frame completion
    always_comb begin
        in_flight = c_v;
        for (int i = 0; i < ROM_LAT; i++) in_flight = in_flight | t_v[i];
        for (int i = 0; i < CONV_LAT - 1; i++) in_flight = in_flight | d_v[i];
    end

    always_comb begin
        state_nx = state;
        rom_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  state_nx = start ? FETCH : IDLE;
            FETCH: begin
                rom_en = adv;
                busy   = 1'b1;
                if (adv && rom_addr == LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready && !in_flight) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            x        <= '0;
            y        <= '0;
            c_v      <= 1'b0;
            c_x      <= '0;
            c_y      <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                t_v[i] <= 1'b0;
                t_x[i] <= '0;
                t_y[i] <= '0;
            end
            for (int i = 0; i < CONV_LAT; i++) begin
                d_v[i] <= 1'b0;
                d_x[i] <= '0;
                d_y[i] <= '0;
            end
        end else if (adv) begin
            if (rom_en) begin
                rom_addr <= rom_addr == LAST ? '0 : rom_addr + 1'b1;
                x        <= x == XMAX ? '0 : x + 1'b1;
                y        <= x == XMAX ? (y == YMAX ? '0 : y + 1'b1) : y;
            end
            t_v[0] <= rom_en;
            t_x[0] <= x;
            t_y[0] <= y;
            for (int i = 1; i < ROM_LAT; i++) begin
                t_v[i] <= t_v[i-1];
                t_x[i] <= t_x[i-1];
                t_y[i] <= t_y[i-1];
            end
            // window is full only once two prior rows and columns exist; row-wrap windows drop out here
            c_v    <= t_v[ROM_LAT-1] && t_x[ROM_LAT-1] >= TWO && t_y[ROM_LAT-1] >= TWO;
            c_x    <= t_x[ROM_LAT-1];
            c_y    <= t_y[ROM_LAT-1];
            d_v[0] <= c_v;
            d_x[0] <= c_x - 1'b1;
            d_y[0] <= c_y - 1'b1;
            for (int i = 1; i < CONV_LAT; i++) begin
                d_v[i] <= d_v[i-1];
                d_x[i] <= d_x[i-1];
                d_y[i] <= d_y[i-1];
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed bench for sobel_frame_ctrl (reset, first output, full frame, backpressure, abort, stray start)
module tb_sobel_frame_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic rom_en, sr_shift, conv_start, pipe_en, out_valid, busy, done;
    logic [AW-1:0] rom_addr, out_x, out_y;

    int checks = 0, failures = 0;
    int nbeat, order_err, last_cyc, ndone, done_cyc, busy_after;
    int f0, addr66, sr67, cs68, cs_early, ov69, ov70, ox70, oy70, nstall, stall_bad;

    always #5 clk = ~clk;

    sobel_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
        .rom_en(rom_en), .rom_addr(rom_addr), .sr_shift(sr_shift), .conv_start(conv_start),
        .pipe_en(pipe_en), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {rom_en, rom_addr, sr_shift, conv_start, pipe_en, out_valid, out_x, out_y, busy, done};
    endfunction

    // cyc 0 is the cycle after the edge that samples start in IDLE
    task automatic run_frame(input int stall_at, input int stall_len, input bit pulses, input int rst_at);
        int ex, ey;
        logic [AW-1:0] h_addr, h_x, h_y;
        ex = 1; ey = 1; nbeat = 0; order_err = 0; last_cyc = -1; ndone = 0; done_cyc = -1;
        busy_after = 1; f0 = 0; addr66 = -1; sr67 = 0; cs68 = 0; cs_early = 0;
        ov69 = 1; ov70 = 0; ox70 = 0; oy70 = 0; nstall = 0; stall_bad = 0;
        h_addr = '0; h_x = '0; h_y = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            start = pulses && (cyc == 10 || cyc == 1025 || cyc == 1028);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            #1;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (cyc == 0)  f0 = busy && rom_en && rom_addr == 0;
            if (cyc == 66) addr66 = rom_addr;
            if (cyc == 67) sr67 = sr_shift;
            if (cyc == 68) cs68 = conv_start;
            if (cyc == 69) ov69 = out_valid;
            if (cyc == 70) begin
                ov70 = out_valid; ox70 = out_x; oy70 = out_y;
            end
            if (cyc < 68 && conv_start) cs_early++;
            if (out_valid && !out_ready) begin
                if (nstall == 0) begin
                    h_addr = rom_addr; h_x = out_x; h_y = out_y;
                end
                nstall++;
                if (rom_en || sr_shift || conv_start || pipe_en ||
                    rom_addr != h_addr || out_x != h_x || out_y != h_y) stall_bad++;
            end
            if (out_valid && out_ready) begin
                if (out_x != AW'(ex) || out_y != AW'(ey)) order_err++;
                nbeat++;
                last_cyc = cyc;
                ex++;
                if (ex == 31) begin
                    ex = 1; ey++;
                end
            end
            if (done) begin
                ndone++; done_cyc = cyc;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int extra);
        chk({tag, " fetch@0"}, f0, 1);
        chk({tag, " rom_addr@66"}, addr66, 66);
        chk({tag, " sr_shift@67"}, sr67, 1);
        chk({tag, " conv_start@68"}, cs68, 1);
        chk({tag, " early_conv_start"}, cs_early, 0);
        chk({tag, " out_valid@69"}, ov69, 0);
        chk({tag, " out_valid@70"}, ov70, 1);
        chk({tag, " out_x@70"}, ox70, 1);
        chk({tag, " out_y@70"}, oy70, 1);
        chk({tag, " beats"}, nbeat, 900);
        chk({tag, " order_err"}, order_err, 0);
        chk({tag, " last_beat_cyc"}, last_cyc, 1027 + extra);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " done_cyc"}, done_cyc, 1028 + extra);
        chk({tag, " busy_after_done"}, busy_after, 0);
        chk({tag, " stall_cycles"}, nstall, extra);
        chk({tag, " stall_bad"}, stall_bad, 0);
    endtask

    initial begin
        // T1: reset held with start high
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("T1 outputs_in_reset", all_out(), 0);
        rst_n = 1'b1;
        // T2/T3: first output timing and full frame
        run_frame(-1, 0, 1'b0, -1);
        check_frame("T3", 0);
        // T4: 5-cycle backpressure at first output
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        run_frame(70, 5, 1'b0, -1);
        check_frame("T4", 5);
        // T5: reset mid-frame at cycle 500
        #2;
        start = 1'b1;
        run_frame(-1, 0, 1'b0, 500);
        chk("T5 no_done_before_abort", ndone, 0);
        @(posedge clk);
        #2;
        chk("T5 outputs_after_abort", all_out(), 0);
        rst_n = 1'b1;
        start = 1'b1;
        run_frame(-1, 0, 1'b0, -1);
        check_frame("T5", 0);
        // T6: start pulses during FETCH/DRAIN/DONE are ignored
        #2;
        start = 1'b1;
        run_frame(-1, 0, 1'b1, -1);
        check_frame("T6", 0);
        repeat (5) @(posedge clk);
        #2;
        chk("T6 idle_after_frame", {busy, done, rom_en}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
